// File: rtl/sc_mult_sched.sv
// sc_mult_sched
//   Sequencer for one stochastic-computing multiply. It accepts an operand
//   pair, then runs two 8-bit LFSR stochastic number generators for
//   STREAM_LEN cycles. It ANDs their bitstreams and counts the ones. The
//   count is returned as the product estimate (op_a*op_b/256 scaled to the
//   stream length).
//
// Ports
//   clk        clock, rising-edge
//   rst        synchronous active-high reset (overrides clear)
//   clear      synchronous abort back to IDLE; any pending result is dropped
//   in_valid   operand pair valid           in_ready  block can accept a pair
//   op_a/op_b  operands, probability op/256
//   out_valid  result valid                 out_ready consumer takes result
//   result     count of ones in the AND stream
//   busy       high while the stream is running
//   bit_y      current AND-stream bit, meaningful only while busy
module sc_mult_sched #(
  parameter int unsigned STREAM_LEN = 255,
  parameter logic [7:0]  SEED_A     = 8'hFF,
  parameter logic [7:0]  SEED_B     = 8'h5A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] result,
  output logic       busy,
  output logic       bit_y
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam logic [7:0] LAST_CYC = 8'(STREAM_LEN - 1);

  state_t     state;
  state_t     state_nxt;

  logic [7:0] op_a_q;
  logic [7:0] op_b_q;
  logic [7:0] lfsr_a;
  logic [7:0] lfsr_b;
  logic [7:0] ones_cnt;
  logic [7:0] cyc_cnt;

  logic       bit_a;
  logic       bit_b;
  logic       accept;
  logic       last_cyc;

  function automatic logic [7:0] lfsr_next(input logic [7:0] r);
    return {r[6:0], r[7] ^ r[5]};
  endfunction

  // Stochastic number generators: a bit is 1 when the operand exceeds the
  // current pseudo-random value, so P(1) = op/256.
  always_comb begin
    bit_a    = (op_a_q > lfsr_a);
    bit_b    = (op_b_q > lfsr_b);
    bit_y    = bit_a & bit_b;
    accept   = (state == IDLE) && in_valid && !clear;
    last_cyc = (state == RUN) && (cyc_cnt == LAST_CYC);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; clear wins over every other transition.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state_nxt = RUN;
        RUN:     if (last_cyc) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == RUN);
  end

  // Datapath. The final RUN cycle folds its own bit into the result directly,
  // so result is ready on the same edge that enters DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a_q   <= '0;
      op_b_q   <= '0;
      lfsr_a   <= SEED_A;
      lfsr_b   <= SEED_B;
      ones_cnt <= '0;
      cyc_cnt  <= '0;
      result   <= '0;
    end else if (accept) begin
      op_a_q   <= op_a;
      op_b_q   <= op_b;
      lfsr_a   <= SEED_A;
      lfsr_b   <= SEED_B;
      ones_cnt <= '0;
      cyc_cnt  <= '0;
    end else if (state == RUN && !clear) begin
      ones_cnt <= ones_cnt + {7'b0, bit_y};
      cyc_cnt  <= cyc_cnt + 8'd1;
      lfsr_a   <= lfsr_next(lfsr_a);
      lfsr_b   <= lfsr_next(lfsr_b);
      if (last_cyc) begin
        result <= ones_cnt + {7'b0, bit_y};
      end
    end
  end

endmodule

// File: tb/tb_sc_mult_sched.sv
// Directed bench for sc_mult_sched: a short-stream instance (STREAM_LEN=4,
// both seeds 8'hFF) with hand-computed results, and a default-parameter
// instance checked against a small LFSR reference model.
module tb_sc_mult_sched;

  logic       clk = 1'b0;
  logic       rst, clear;
  logic       in_valid, out_ready;
  logic [7:0] op_a, op_b;
  logic       in_ready, out_valid, busy, bit_y;
  logic [7:0] result;

  logic       d_in_valid, d_out_ready;
  logic [7:0] d_op_a, d_op_b;
  logic       d_in_ready, d_out_valid, d_busy, d_bit_y;
  logic [7:0] d_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sc_mult_sched #(
    .STREAM_LEN(4),
    .SEED_A    (8'hFF),
    .SEED_B    (8'hFF)
  ) dut4 (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .busy     (busy),
    .bit_y    (bit_y)
  );

  sc_mult_sched dutd (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (d_in_valid),
    .in_ready (d_in_ready),
    .op_a     (d_op_a),
    .op_b     (d_op_b),
    .out_valid(d_out_valid),
    .out_ready(d_out_ready),
    .result   (d_result),
    .busy     (d_busy),
    .bit_y    (d_bit_y)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full run on the short instance: latency, busy length, result, handoff.
  task automatic run4(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp, input string tag);
    int cyc;
    int busy_n;
    op_a = a; op_b = b; in_valid = 1'b1; out_ready = 1'b0;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    op_a = ~a; op_b = ~b;  // must not affect the run
    chk({tag, "_bit_first"}, 32'(bit_y), 32'd0);
    cyc = 1; busy_n = 0;
    while (!out_valid && cyc < 20) begin
      busy_n += int'(busy);
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, cyc, 32'd5);
    chk({tag, "_busy_cycles"}, busy_n, 32'd4);
    chk({tag, "_result"}, 32'(result), 32'(exp));
    chk({tag, "_ready_in_done"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_def(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] exp, input string tag);
    int cyc;
    d_op_a = a; d_op_b = b; d_in_valid = 1'b1; d_out_ready = 1'b0;
    tick();
    d_in_valid = 1'b0;
    cyc = 1;
    while (!d_out_valid && cyc < 300) begin
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, cyc, 32'd256);
    chk({tag, "_result"}, 32'(d_result), 32'(exp));
    d_out_ready = 1'b1;
    tick();
    d_out_ready = 1'b0;
    chk({tag, "_idle"}, 32'(d_in_ready), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    chk({tag, "_reached_done"}, 32'(out_valid), 32'd1);
  endtask

  initial begin
    logic [7:0] la, lb, mcnt;
    logic       seen;

    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0;
    d_in_valid = 1'b0; d_out_ready = 1'b0; d_op_a = '0; d_op_b = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_d_in_ready", 32'(d_in_ready), 32'd1);

    // Hand-computed short streams: LFSR FF,FE,FC,F8
    run4(8'hFD, 8'hFD, 8'd2, "fd_fd");
    run4(8'hFF, 8'hFF, 8'd3, "ff_ff");
    run4(8'h00, 8'hFF, 8'd0, "00_ff");

    // Backpressure: DONE holds for 10 cycles with a new pair waiting
    op_a = 8'hFF; op_b = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done("bp");
    op_a = 8'hFD; op_b = 8'hFD; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_result", 32'(result), 32'd3);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_idle_ready", 32'(in_ready), 32'd1);
    chk("bp_idle_valid", 32'(out_valid), 32'd0);
    chk("bp_idle_busy", 32'(busy), 32'd0);
    tick();
    in_valid = 1'b0;
    chk("bp_next_accept", 32'(busy), 32'd1);
    wait_done("bp2");
    chk("bp2_result", 32'(result), 32'd2);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // clear on RUN cycle 2
    op_a = 8'hFF; op_b = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("clr_running", 32'(busy), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_in_ready", 32'(in_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen |= out_valid;
      tick();
    end
    chk("clr_no_valid", 32'(seen), 32'd0);
    run4(8'hFD, 8'hFD, 8'd2, "reseed");

    // clear beats in_valid in IDLE
    op_a = 8'hFF; op_b = 8'hFF; in_valid = 1'b1; clear = 1'b1;
    tick();
    in_valid = 1'b0; clear = 1'b0;
    chk("clr_vs_valid_busy", 32'(busy), 32'd0);
    chk("clr_vs_valid_ready", 32'(in_ready), 32'd1);

    // rst in DONE together with in_valid and clear
    op_a = 8'hFF; op_b = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_done("rd");
    chk("rd_result_pre", 32'(result), 32'd3);
    rst = 1'b1; clear = 1'b1; in_valid = 1'b1; op_a = 8'hFD; op_b = 8'hFD;
    tick();
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
    chk("rd_out_valid", 32'(out_valid), 32'd0);
    chk("rd_result", 32'(result), 32'd0);
    chk("rd_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("rd_no_capture", 32'(busy), 32'd0);

    // Default parameters
    run_def(8'hA5, 8'h00, 8'd0, "def_b0");
    la = 8'hFF; lb = 8'h5A; mcnt = '0;
    for (int i = 0; i < 255; i++) begin
      if ((8'hFF > la) && (8'hFF > lb)) mcnt++;
      la = {la[6:0], la[7] ^ la[5]};
      lb = {lb[6:0], lb[7] ^ lb[5]};
    end
    run_def(8'hFF, 8'hFF, mcnt, "def_ff");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
